// File: rtl/bcd_convert_arbiter.sv
// bcd_convert_arbiter: round-robin sequencer sharing one Binary_to_BCD
// converter among NUM_REQ OSD field requesters, with a watchdog that
// aborts a conversion that never returns data-valid.
// Optional build macro: OSD_BCD_CACHE_EN (per-requester result cache).
module bcd_convert_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int INPUT_WIDTH    = 16,
    parameter int DECIMAL_DIGITS = 5,
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic                            i_Clock,
    input  logic                            i_Reset,
    input  logic [NUM_REQ-1:0]              i_Req,
    input  logic [NUM_REQ*INPUT_WIDTH-1:0]  i_Binary,
    output logic [NUM_REQ-1:0]              o_Grant,
    output logic [DECIMAL_DIGITS*4-1:0]     o_BCD,
    output logic [NUM_REQ-1:0]              o_Done,
    output logic                            o_Timeout,
    output logic                            o_Busy,
    output logic                            o_Conv_Start,
    output logic [INPUT_WIDTH-1:0]          o_Conv_Binary,
    input  logic [DECIMAL_DIGITS*4-1:0]     i_Conv_BCD,
    input  logic                            i_Conv_DV
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int WD_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam int BCD_W = DECIMAL_DIGITS * 4;

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_WAIT,
        S_DONE
    } state_t;

    state_t                 r_state;
    logic [IDX_W-1:0]       r_ptr;
    logic [IDX_W-1:0]       r_idx;
    logic [WD_W-1:0]        r_wd;
    logic [NUM_REQ-1:0]     r_grant;
    logic [BCD_W-1:0]       r_bcd;
    logic [NUM_REQ-1:0]     r_done;
    logic                   r_timeout;
    logic                   r_busy;
    logic                   r_conv_start;
    logic [INPUT_WIDTH-1:0] r_conv_bin;

    logic                   w_found;
    logic [IDX_W-1:0]       w_sel;
    logic [IDX_W:0]         w_sum;
    logic [INPUT_WIDTH-1:0] w_sel_bin;
    logic [NUM_REQ-1:0]     w_sel_onehot;
    logic [NUM_REQ-1:0]     w_idx_onehot;
    logic [IDX_W-1:0]       w_ptr_next;
    logic                   w_conv_ok;
    logic                   w_wd_expire;

    // Round-robin search: first requester at or after the pointer, with wrap
    always_comb begin
        w_found = 1'b0;
        w_sel   = '0;
        w_sum   = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            w_sum = {1'b0, r_ptr} + (IDX_W+1)'(i);
            if (w_sum >= (IDX_W+1)'(NUM_REQ)) begin
                w_sum = w_sum - (IDX_W+1)'(NUM_REQ);
            end
            if (!w_found && i_Req[w_sum[IDX_W-1:0]]) begin
                w_found = 1'b1;
                w_sel   = w_sum[IDX_W-1:0];
            end
        end
    end

    // Binary slice of the selected requester
    always_comb begin
        w_sel_bin = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (w_sel == IDX_W'(i)) begin
                w_sel_bin = i_Binary[i*INPUT_WIDTH +: INPUT_WIDTH];
            end
        end
    end

    assign w_sel_onehot = NUM_REQ'(1) << w_sel;
    assign w_idx_onehot = NUM_REQ'(1) << r_idx;
    assign w_ptr_next   = (r_idx == IDX_W'(NUM_REQ - 1)) ? '0 : r_idx + 1'b1;
    assign w_conv_ok    = (r_state == S_WAIT) && i_Conv_DV;
    assign w_wd_expire  = (r_state == S_WAIT) && !i_Conv_DV &&
                          (r_wd == WD_W'(TIMEOUT_CYCLES - 1));

`ifdef OSD_BCD_CACHE_EN
    logic [INPUT_WIDTH-1:0] r_cache_bin [NUM_REQ];
    logic [BCD_W-1:0]       r_cache_bcd [NUM_REQ];
    logic [NUM_REQ-1:0]     r_cache_vld;
    logic                   w_hit;

    assign w_hit = r_cache_vld[w_sel] && (r_cache_bin[w_sel] == w_sel_bin);

    // Cache payload: written on every successful conversion
    always_ff @(posedge i_Clock) begin
        if (w_conv_ok) begin
            r_cache_bin[r_idx] <= r_conv_bin;
            r_cache_bcd[r_idx] <= i_Conv_BCD;
        end
    end

    // Cache valid bits: set on conversion, cleared on watchdog abort
    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            r_cache_vld <= '0;
        end else if (w_conv_ok) begin
            r_cache_vld[r_idx] <= 1'b1;
        end else if (w_wd_expire) begin
            r_cache_vld[r_idx] <= 1'b0;
        end
    end
`endif

    // Sequencer FSM with registered outputs
    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            r_state      <= S_IDLE;
            r_ptr        <= '0;
            r_idx        <= '0;
            r_wd         <= '0;
            r_grant      <= '0;
            r_bcd        <= '0;
            r_done       <= '0;
            r_timeout    <= 1'b0;
            r_busy       <= 1'b0;
            r_conv_start <= 1'b0;
            r_conv_bin   <= '0;
        end else begin
            r_conv_start <= 1'b0;
            r_done       <= '0;
            r_timeout    <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_idx      <= w_sel;
                        r_conv_bin <= w_sel_bin;
                        r_grant    <= w_sel_onehot;
                        r_busy     <= 1'b1;
`ifdef OSD_BCD_CACHE_EN
                        if (w_hit) begin
                            r_bcd   <= r_cache_bcd[w_sel];
                            r_done  <= w_sel_onehot;
                            r_state <= S_DONE;
                        end else
`endif
                        begin
                            r_conv_start <= 1'b1;
                            r_state      <= S_START;
                        end
                    end
                end
                S_START: begin
                    r_wd    <= '0;
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    r_wd <= r_wd + 1'b1;
                    if (w_conv_ok) begin
                        r_bcd   <= i_Conv_BCD;
                        r_done  <= w_idx_onehot;
                        r_state <= S_DONE;
                    end else if (w_wd_expire) begin
                        r_bcd     <= '1;
                        r_done    <= w_idx_onehot;
                        r_timeout <= 1'b1;
                        r_state   <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_grant <= '0;
                    r_busy  <= 1'b0;
                    r_ptr   <= w_ptr_next;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_Grant       = r_grant;
    assign o_BCD         = r_bcd;
    assign o_Done        = r_done;
    assign o_Timeout     = r_timeout;
    assign o_Busy        = r_busy;
    assign o_Conv_Start  = r_conv_start;
    assign o_Conv_Binary = r_conv_bin;

endmodule

// File: tb/tb_bcd_convert_arbiter.sv
// Self-checking bench for bcd_convert_arbiter with a behavioural converter
// model and a round-robin reference model. Honours OSD_BCD_CACHE_EN.
module tb_bcd_convert_arbiter;

    localparam int NR = 4;
    localparam int IW = 16;
    localparam int DD = 5;
    localparam int TO = 40;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [NR-1:0]     req = '0;
    logic [NR*IW-1:0]  bin = '0;
    logic [NR-1:0]     grant;
    logic [DD*4-1:0]   bcd;
    logic [NR-1:0]     done;
    logic              tmo;
    logic              busy;
    logic              cstart;
    logic [IW-1:0]     cbin;
    logic [DD*4-1:0]   conv_bcd = '0;
    logic              conv_dv = 1'b0;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    // converter model state
    bit              conv_enable = 1'b1;
    int              conv_lat = 3;
    int              conv_cnt = 0;
    logic [DD*4-1:0] conv_pending = '0;
    int              start_count = 0;
    int              dv_cyc = -1;

    bcd_convert_arbiter #(
        .NUM_REQ(NR),
        .INPUT_WIDTH(IW),
        .DECIMAL_DIGITS(DD),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .i_Clock(clk),
        .i_Reset(rst),
        .i_Req(req),
        .i_Binary(bin),
        .o_Grant(grant),
        .o_BCD(bcd),
        .o_Done(done),
        .o_Timeout(tmo),
        .o_Busy(busy),
        .o_Conv_Start(cstart),
        .o_Conv_Binary(cbin),
        .i_Conv_BCD(conv_bcd),
        .i_Conv_DV(conv_dv)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [DD*4-1:0] to_bcd(input int unsigned v);
        logic [DD*4-1:0] r;
        int unsigned p;
        r = '0;
        p = 1;
        for (int d = 0; d < DD; d++) begin
            r[4*d +: 4] = 4'((v / p) % 10);
            p = p * 10;
        end
        return r;
    endfunction

    // Converter: no reset, answers conv_lat cycles after a start it accepts
    always @(negedge clk) begin
        conv_dv = 1'b0;
        if (conv_cnt > 0) begin
            conv_cnt = conv_cnt - 1;
            if (conv_cnt == 0) begin
                conv_dv  = 1'b1;
                conv_bcd = conv_pending;
                dv_cyc   = cyc;
            end
        end
        if (cstart === 1'b1) begin
            start_count++;
            if (conv_enable) begin
                conv_pending = to_bcd(32'(cbin));
                conv_cnt     = conv_lat;
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = '0;
        conv_cnt = 0;
        conv_enable = 1'b1;
        conv_lat = 3;
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic wait_start(input int lim, output bit ok, output int n);
        ok = 1'b0;
        n = 0;
        while (!ok && n < lim) begin
            tick();
            n++;
            if (cstart === 1'b1) ok = 1'b1;
        end
    endtask

    task automatic wait_done(input int lim, output bit ok, output int n);
        ok = 1'b0;
        n = 0;
        while (!ok && n < lim) begin
            tick();
            n++;
            if ((|done) === 1'b1) ok = 1'b1;
        end
    endtask

    task automatic test_reset();
        do_reset();
        vectors++;
        if ({grant, bcd, done, tmo, busy, cstart, cbin} !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs: got grant=%b bcd=%h done=%b tmo=%b busy=%b start=%b cbin=%h, expected all zero",
                     grant, bcd, done, tmo, busy, cstart, cbin);
        end
    endtask

    task automatic test_single();
        bit ok;
        int n;
        int s0;
        do_reset();
        s0 = start_count;
        bin[0 +: IW] = 16'd1234;
        req = 4'b0001;
        wait_start(10, ok, n);
        vectors++;
        if (!ok || n != 1) begin
            miscompares++;
            $display("FAIL single_start_latency: got ok=%0d cycles=%0d, expected start after 1", ok, n);
        end
        vectors++;
        if (cbin !== 16'd1234 || grant !== 4'b0001 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL single_start_state: got cbin=%0d grant=%b busy=%b, expected 1234 0001 1", cbin, grant, busy);
        end
        wait_done(20, ok, n);
        vectors++;
        if (!ok || done !== 4'b0001 || bcd !== 20'h01234 || tmo !== 1'b0) begin
            miscompares++;
            $display("FAIL single_done: got ok=%0d done=%b bcd=%h tmo=%b, expected 0001 01234 0", ok, done, bcd, tmo);
        end
        vectors++;
        if (cyc != dv_cyc + 1) begin
            miscompares++;
            $display("FAIL single_dv_to_done: got cycle %0d, expected %0d", cyc, dv_cyc + 1);
        end
        vectors++;
        if (start_count - s0 != 1) begin
            miscompares++;
            $display("FAIL single_start_count: got %0d, expected 1", start_count - s0);
        end
        req = '0;
        tick();
        vectors++;
        if (done !== 4'b0000 || grant !== 4'b0000 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL single_after_done: got done=%b grant=%b busy=%b, expected 0000 0000 0", done, grant, busy);
        end
    endtask

    task automatic test_contention();
        bit ok;
        int n;
        int unsigned v [NR];
        logic [NR-1:0] e;
        do_reset();
        v[0] = 1; v[1] = 22; v[2] = 333; v[3] = 4444;
        for (int k = 0; k < NR; k++) bin[k*IW +: IW] = IW'(v[k]);
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            e = NR'(1) << (k % NR);
            wait_done(30, ok, n);
            vectors++;
            if (!ok || done !== e || grant !== e || bcd !== to_bcd(v[k % NR])) begin
                miscompares++;
                $display("FAIL contention_%0d: got ok=%0d done=%b grant=%b bcd=%h, expected %b %b %h",
                         k, ok, done, grant, bcd, e, e, to_bcd(v[k % NR]));
            end
        end
        req = '0;
        tick();
        tick();
    endtask

    task automatic test_timeout();
        bit ok;
        int n;
        do_reset();
        conv_enable = 1'b0;
        bin[1*IW +: IW] = 16'd555;
        req = 4'b0010;
        wait_start(10, ok, n);
        wait_done(TO + 10, ok, n);
        vectors++;
        if (!ok || n != TO + 1) begin
            miscompares++;
            $display("FAIL timeout_latency: got ok=%0d cycles=%0d, expected %0d", ok, n, TO + 1);
        end
        vectors++;
        if (done !== 4'b0010 || tmo !== 1'b1 || bcd !== 20'hFFFFF) begin
            miscompares++;
            $display("FAIL timeout_done: got done=%b tmo=%b bcd=%h, expected 0010 1 fffff", done, tmo, bcd);
        end
        conv_enable = 1'b1;
        bin[3*IW +: IW] = 16'd4321;
        bin[0 +: IW] = 16'd17;
        req = 4'b1001;
        wait_done(30, ok, n);
        vectors++;
        if (!ok || done !== 4'b1000 || bcd !== 20'h04321 || tmo !== 1'b0) begin
            miscompares++;
            $display("FAIL timeout_next: got ok=%0d done=%b bcd=%h tmo=%b, expected 1000 04321 0", ok, done, bcd, tmo);
        end
        req = '0;
        tick();
        tick();
    endtask

    task automatic test_reset_in_wait();
        bit ok;
        int n;
        bit any_done;
        bit any_busy;
        int dv0;
        do_reset();
        conv_lat = 10;
        bin[0 +: IW] = 16'd5;
        req = 4'b0001;
        wait_start(10, ok, n);
        tick();
        tick();
        dv0 = dv_cyc;
        rst = 1'b1;
        req = '0;
        tick();
        rst = 1'b0;
        any_done = 1'b0;
        any_busy = 1'b0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (done !== 4'b0000) any_done = 1'b1;
            if (busy !== 1'b0) any_busy = 1'b1;
        end
        vectors++;
        if (any_done || any_busy || bcd !== 20'h0 || dv_cyc == dv0) begin
            miscompares++;
            $display("FAIL reset_in_wait: got done_seen=%0d busy_seen=%0d bcd=%h stray_dv_sent=%0d, expected 0 0 00000 1",
                     any_done, any_busy, bcd, dv_cyc != dv0);
        end
        conv_lat = 3;
    endtask

    task automatic test_value_change();
        bit ok;
        int n;
        do_reset();
        bin[1*IW +: IW] = 16'd99;
        req = 4'b0010;
        wait_start(10, ok, n);
        tick();
        bin[1*IW +: IW] = 16'd7;
        tick();
        vectors++;
        if (cbin !== 16'd99) begin
            miscompares++;
            $display("FAIL value_change_latch: got cbin=%0d, expected 99", cbin);
        end
        wait_done(20, ok, n);
        vectors++;
        if (!ok || done !== 4'b0010 || bcd !== 20'h00099 || cbin !== 16'd99) begin
            miscompares++;
            $display("FAIL value_change_result: got ok=%0d done=%b bcd=%h cbin=%0d, expected 0010 00099 99",
                     ok, done, bcd, cbin);
        end
        req = '0;
        tick();
    endtask

    task automatic test_repeat_value();
        bit ok;
        int n;
        int s0;
        do_reset();
        bin[0 +: IW] = 16'd65535;
        req = 4'b0001;
        wait_done(20, ok, n);
        vectors++;
        if (!ok || bcd !== 20'h65535) begin
            miscompares++;
            $display("FAIL repeat_first: got ok=%0d bcd=%h, expected 65535", ok, bcd);
        end
        req = '0;
        tick();
        tick();
        s0 = start_count;
        req = 4'b0001;
`ifdef OSD_BCD_CACHE_EN
        tick();
        vectors++;
        if (done !== 4'b0001 || bcd !== 20'h65535 || tmo !== 1'b0 || start_count != s0) begin
            miscompares++;
            $display("FAIL repeat_cache_hit: got done=%b bcd=%h tmo=%b starts=%0d, expected 0001 65535 0 0",
                     done, bcd, tmo, start_count - s0);
        end
`else
        wait_done(20, ok, n);
        vectors++;
        if (!ok || done !== 4'b0001 || bcd !== 20'h65535 || start_count - s0 != 1) begin
            miscompares++;
            $display("FAIL repeat_reconvert: got ok=%0d done=%b bcd=%h starts=%0d, expected 0001 65535 1",
                     ok, done, bcd, start_count - s0);
        end
`endif
        req = '0;
        tick();
    endtask

    task automatic test_random();
        bit ok;
        int n;
        int ptr;
        int exp_idx;
        bit pend [NR];
        int unsigned vals [NR];
        logic [NR-1:0] e;
        int unsigned nv;
        do_reset();
        ptr = 0;
        for (int k = 0; k < NR; k++) begin
            pend[k] = 1'($urandom_range(0, 1));
            vals[k] = $urandom_range(0, 65535);
        end
        pend[$urandom_range(0, NR - 1)] = 1'b1;
        for (int k = 0; k < NR; k++) begin
            req[k] = pend[k];
            bin[k*IW +: IW] = IW'(vals[k]);
        end
        for (int t = 0; t < 40; t++) begin
            conv_lat = $urandom_range(1, 8);
            exp_idx = -1;
            for (int off = 0; off < NR; off++) begin
                if (exp_idx < 0 && pend[(ptr + off) % NR]) exp_idx = (ptr + off) % NR;
            end
            e = NR'(1) << exp_idx;
            wait_start(10, ok, n);
            vectors++;
            if (!ok || cbin !== IW'(vals[exp_idx]) || grant !== e) begin
                miscompares++;
                $display("FAIL random_start_%0d: got ok=%0d cbin=%0d grant=%b, expected %0d %b",
                         t, ok, cbin, grant, vals[exp_idx], e);
            end
            wait_done(TO, ok, n);
            vectors++;
            if (!ok || done !== e || bcd !== to_bcd(vals[exp_idx]) || tmo !== 1'b0) begin
                miscompares++;
                $display("FAIL random_done_%0d: got ok=%0d done=%b bcd=%h tmo=%b, expected %b %h 0",
                         t, ok, done, bcd, tmo, e, to_bcd(vals[exp_idx]));
            end
            ptr = (exp_idx + 1) % NR;
            pend[exp_idx] = 1'b0;
            for (int k = 0; k < NR; k++) begin
                if (!pend[k] && $urandom_range(0, 1) == 1) begin
                    nv = $urandom_range(0, 65535);
                    if (nv == vals[k]) nv = nv ^ 1;
                    vals[k] = nv;
                    pend[k] = 1'b1;
                end
            end
            if (!(pend[0] | pend[1] | pend[2] | pend[3])) begin
                nv = $urandom_range(0, 65535);
                if (nv == vals[ptr]) nv = nv ^ 1;
                vals[ptr] = nv;
                pend[ptr] = 1'b1;
            end
            for (int k = 0; k < NR; k++) begin
                req[k] = pend[k];
                bin[k*IW +: IW] = IW'(vals[k]);
            end
        end
        req = '0;
        tick();
        tick();
    endtask

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_timeout();
        test_reset_in_wait();
        test_value_change();
        test_repeat_value();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_time_limit: simulation still running at %0t, expected completion", $time);
        $fatal(1);
    end

endmodule
